weight_buffer_loader: RTL and testbench

- Writer side of the weight buffer. Accepts a stream of weight words over a valid/ready handshake and writes them into the per-layer, per-feature-vector weight buffer, one word per cycle.
- Sits between the off-chip/host weight stream and the weight buffer storage that the weight controller reads during compute.
- Signals load completion so the reservation station can fire the weight controller only after a full, consistent load.

---
 rtl/weight_buffer_loader_pkg.sv | 26 ++
 rtl/weight_load_addr_gen.sv | 46 ++++
 rtl/weight_buffer_loader.sv | 143 ++++++++++++++
 tb/tb_weight_buffer_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_buffer_loader_pkg.sv
// Shared types and default sizing for the weight buffer write path.
// Used by the loader, its address generator and the weight buffer storage.
package weight_buffer_loader_pkg;

    localparam int DEF_MAX_LAYERS = 4;
    localparam int DEF_MAX_FV     = 16;
    localparam int DEF_FV_SIZE    = 16;

    localparam int DEF_LAYER_W = $clog2(DEF_MAX_LAYERS);
    localparam int DEF_IDX_W   = $clog2(DEF_MAX_FV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_t;

    // One write into the weight buffer, at the default geometry.
    typedef struct packed {
        logic                   en;
        logic [DEF_LAYER_W-1:0] layer;
        logic [DEF_IDX_W-1:0]   idx;
        logic [DEF_FV_SIZE-1:0] data;
    } weight_wr_t;

endpackage

// File: rtl/weight_load_addr_gen.sv
// Layer-major (layer, index) counter with wrap and last-entry detection.
// Kept separate so a readback path can walk the buffer in the same order.
module weight_load_addr_gen
    import weight_buffer_loader_pkg::*;
#(
    parameter int LAYER_W = DEF_LAYER_W,
    parameter int IDX_W   = DEF_IDX_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               advance,
    input  logic [LAYER_W-1:0] last_layer,
    input  logic [IDX_W:0]     num_fv,
    output logic [LAYER_W-1:0] layer,
    output logic [IDX_W-1:0]   idx,
    output logic               last
);

    logic [IDX_W:0] idx_ext;
    logic [IDX_W:0] idx_end;
    logic           idx_last;

    // Compare at IDX_W+1 bits so a full-depth layer (num_fv == MAX_FV) wraps.
    assign idx_ext  = {1'b0, idx};
    assign idx_end  = num_fv - (IDX_W+1)'(1);
    assign idx_last = (idx_ext == idx_end);
    assign last     = idx_last && (layer == last_layer);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            layer <= '0;
            idx   <= '0;
        end else if (advance) begin
            if (idx_last) begin
                idx <= '0;
                if (!last) begin
                    layer <= layer + LAYER_W'(1);
                end
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/weight_buffer_loader.sv
// Writer side of the weight buffer: streams weight words into (layer, index) slots.
// Define WEIGHT_LOAD_CHECKSUM_EN to add a running checksum and a mismatch flag.
module weight_buffer_loader
    import weight_buffer_loader_pkg::*;
#(
    parameter int MAX_LAYERS = DEF_MAX_LAYERS,
    parameter int MAX_FV     = DEF_MAX_FV,
    parameter int FV_SIZE    = DEF_FV_SIZE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [$clog2(MAX_LAYERS)-1:0] num_layer,
    input  logic [$clog2(MAX_FV):0]       num_fv,
    input  logic                          in_valid,
    input  logic [FV_SIZE-1:0]            in_data,
    output logic                          in_ready,
    output logic                          wr_en,
    output logic [$clog2(MAX_LAYERS)-1:0] wr_layer,
    output logic [$clog2(MAX_FV)-1:0]     wr_idx,
    output logic [FV_SIZE-1:0]            wr_data,
    output logic                          busy,
    output logic                          load_done
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    ,
    input  logic [FV_SIZE-1:0]            exp_checksum,
    output logic [FV_SIZE-1:0]            checksum,
    output logic                          chk_err
`endif
);

    localparam int LW = $clog2(MAX_LAYERS);
    localparam int IW = $clog2(MAX_FV);
    localparam int CW = IW + 1;

    load_state_t   state_q;
    load_state_t   state_d;
    logic [LW-1:0] num_layer_q;
    logic [CW-1:0] num_fv_q;
    logic          start_ok;
    logic          accept;
    logic          last;
    logic [LW-1:0] layer;
    logic [IW-1:0] idx;

    // Handshake: in_ready depends only on state (high in LOAD); a word transfers
    // in any cycle where in_valid && in_ready, and in_data is ignored otherwise.
    assign in_ready = (state_q == LOAD);
    assign accept   = in_valid && in_ready;
    assign start_ok = start && (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (num_fv == '0) ? DONE : LOAD;
            LOAD:    if (accept && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            num_layer_q <= '0;
            num_fv_q    <= '0;
        end else if (start_ok) begin
            num_layer_q <= num_layer;
            num_fv_q    <= (num_fv > CW'(MAX_FV)) ? CW'(MAX_FV) : num_fv;
        end
    end

    weight_load_addr_gen #(
        .LAYER_W (LW),
        .IDX_W   (IW)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .advance    (accept),
        .last_layer (num_layer_q),
        .num_fv     (num_fv_q),
        .layer      (layer),
        .idx        (idx),
        .last       (last)
    );

    // Registered write port: a word accepted in cycle N is written in cycle N+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en    <= 1'b0;
            wr_layer <= '0;
            wr_idx   <= '0;
            wr_data  <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_layer <= layer;
                wr_idx   <= idx;
                wr_data  <= in_data;
            end
        end
    end

    // DONE lines up with the final write, or follows start directly on an empty load.
    assign load_done = (state_q == DONE);
    assign busy      = (state_q != IDLE);

`ifdef WEIGHT_LOAD_CHECKSUM_EN
    logic [FV_SIZE-1:0] sum_q;
    logic [FV_SIZE-1:0] sum_d;
    logic               chk_err_q;

    assign sum_d = sum_q + in_data;

    // The flag is computed one cycle early so it is visible with load_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q     <= '0;
            chk_err_q <= 1'b0;
        end else if (start_ok) begin
            sum_q     <= '0;
            chk_err_q <= (num_fv == '0) && (exp_checksum != '0);
        end else if (accept) begin
            sum_q <= sum_d;
            if (last) begin
                chk_err_q <= (sum_d != exp_checksum);
            end
        end
    end

    assign checksum = sum_q;
    assign chk_err  = chk_err_q;
`endif

endmodule

// File: tb/tb_weight_buffer_loader.sv
// Directed bench for weight_buffer_loader; checksum steps build when
// WEIGHT_LOAD_CHECKSUM_EN is defined.
module tb_weight_buffer_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  num_layer;
    logic [4:0]  num_fv;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        wr_en;
    logic [1:0]  wr_layer;
    logic [3:0]  wr_idx;
    logic [15:0] wr_data;
    logic        busy;
    logic        load_done;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    logic [15:0] exp_checksum;
    logic [15:0] checksum;
    logic        chk_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    weight_buffer_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_layer    (num_layer),
        .num_fv       (num_fv),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .wr_en        (wr_en),
        .wr_layer     (wr_layer),
        .wr_idx       (wr_idx),
        .wr_data      (wr_data),
        .busy         (busy),
        .load_done    (load_done)
`ifdef WEIGHT_LOAD_CHECKSUM_EN
        ,
        .exp_checksum (exp_checksum),
        .checksum     (checksum),
        .chk_err      (chk_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input logic en, input int layer, input int idx,
                            input int data, input logic done);
        check({tag, ".wr_en"}, 32'(wr_en), 32'(en));
        if (en) begin
            check({tag, ".wr_layer"}, 32'(wr_layer), layer);
            check({tag, ".wr_idx"}, 32'(wr_idx), idx);
            check({tag, ".wr_data"}, 32'(wr_data), data);
        end
        check({tag, ".load_done"}, 32'(load_done), 32'(done));
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        num_layer = 2'd0;
        num_fv    = 5'd0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
        exp_checksum = 16'h0;
`endif
        cyc();
        cyc();
        check("rst.in_ready", 32'(in_ready), 0);
        check("rst.wr_en", 32'(wr_en), 0);
        check("rst.wr_layer", 32'(wr_layer), 0);
        check("rst.wr_idx", 32'(wr_idx), 0);
        check("rst.wr_data", 32'(wr_data), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.load_done", 32'(load_done), 0);
        reset = 1'b0;
        cyc();

        // Full load: 2 layers x 4 entries, data 1..8 back to back.
        start = 1'b1; num_layer = 2'd1; num_fv = 5'd4;
        in_valid = 1'b1; in_data = 16'hDEAD;   // not accepted while IDLE
        cyc();
        start = 1'b0;
        check("full.in_ready", 32'(in_ready), 1);
        check("full.busy", 32'(busy), 1);
        check_wr("full.first", 1'b0, 0, 0, 0, 1'b0);
        in_data = 16'd1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            check_wr("full.w", 1'b1, (k - 1) / 4, (k - 1) % 4, k, k == 8);
            check("full.busy_mid", 32'(busy), 1);
            check("full.in_ready_mid", 32'(in_ready), 32'(k < 8));
            if (k < 8) in_data = 16'(k + 1);
            else in_valid = 1'b0;
        end
        cyc();
        check("full.busy_end", 32'(busy), 0);
        check_wr("full.after", 1'b0, 0, 0, 0, 1'b0);

        // Gaps: one layer of 3 entries, in_valid 1,0,1,0,1.
        start = 1'b1; num_layer = 2'd0; num_fv = 5'd3;
        cyc();
        start = 1'b0;
        for (int j = 0; j <= 4; j++) begin
            in_valid = (j % 2 == 0);
            in_data  = 16'(16'hA0 + j);
            cyc();
            if (j % 2 == 0) check_wr("gap.w", 1'b1, 0, j / 2, 16'hA0 + j, j == 4);
            else check_wr("gap.idle", 1'b0, 0, 0, 0, 1'b0);
        end
        in_valid = 1'b0;
        cyc();
        check("gap.busy_end", 32'(busy), 0);
        check_wr("gap.after", 1'b0, 0, 0, 0, 1'b0);

        // Empty load: no writes, done one cycle after start.
        start = 1'b1; num_layer = 2'd2; num_fv = 5'd0;
        in_valid = 1'b1; in_data = 16'hBEEF;
        cyc();
        start = 1'b0;
        check("empty.busy", 32'(busy), 1);
        check("empty.in_ready", 32'(in_ready), 0);
        check_wr("empty.done", 1'b0, 0, 0, 0, 1'b1);
        cyc();
        check("empty.busy_end", 32'(busy), 0);
        check_wr("empty.after", 1'b0, 0, 0, 0, 1'b0);
        in_valid = 1'b0;

        // Saturation: num_fv=20 clamps to 16 entries.
        start = 1'b1; num_layer = 2'd0; num_fv = 5'd20;
        cyc();
        start = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_data = 16'(16'h100 + k);
            cyc();
            check_wr("sat.w", 1'b1, 0, k, 16'h100 + k, k == 15);
        end
        in_data = 16'h1FF;
        cyc();
        check("sat.busy_end", 32'(busy), 0);
        check_wr("sat.after", 1'b0, 0, 0, 0, 1'b0);
        in_valid = 1'b0;

        // Start re-pulsed mid-load must be ignored.
        start = 1'b1; num_layer = 2'd0; num_fv = 5'd4;
        cyc();
        start = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 16'(16'h200 + k);
            if (k == 1) begin
                start = 1'b1; num_layer = 2'd1; num_fv = 5'd2;
            end
            cyc();
            start = 1'b0;
            check_wr("ign.w", 1'b1, 0, k, 16'h200 + k, k == 3);
        end
        in_valid = 1'b0;
        cyc();
        check("ign.busy_end", 32'(busy), 0);

        // Reset after two words drops the pending write.
        start = 1'b1; num_layer = 2'd1; num_fv = 5'd4;
        cyc();
        start = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_data = 16'(16'h300 + k);
            cyc();
            check_wr("rmid.w", 1'b1, 0, k, 16'h300 + k, 1'b0);
        end
        in_data = 16'h302;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        in_valid = 1'b0;
        check("rmid.wr_en", 32'(wr_en), 0);
        check("rmid.busy", 32'(busy), 0);
        check("rmid.in_ready", 32'(in_ready), 0);
        check("rmid.wr_idx", 32'(wr_idx), 0);
        start = 1'b1; num_layer = 2'd0; num_fv = 5'd1;
        cyc();
        start = 1'b0;
        in_valid = 1'b1; in_data = 16'h400;
        cyc();
        in_valid = 1'b0;
        check_wr("rmid.restart", 1'b1, 0, 0, 16'h400, 1'b1);
        cyc();

`ifdef WEIGHT_LOAD_CHECKSUM_EN
        // Checksum of 1+2+3 against a matching and a wrong expectation.
        for (int t = 0; t < 2; t++) begin
            exp_checksum = (t == 0) ? 16'h0006 : 16'h0007;
            start = 1'b1; num_layer = 2'd0; num_fv = 5'd3;
            cyc();
            start = 1'b0;
            check("chk.clear", 32'(checksum), 0);
            in_valid = 1'b1;
            for (int k = 1; k <= 3; k++) begin
                in_data = 16'(k);
                cyc();
            end
            in_valid = 1'b0;
            check("chk.done", 32'(load_done), 1);
            check("chk.sum", 32'(checksum), 6);
            check("chk.err", 32'(chk_err), 32'(t));
            cyc();
            check("chk.err_hold", 32'(chk_err), 32'(t));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
